imm_encoder: RTL and testbench

Immediate encoder for the instruction-assembly path. It is the inverse of immediate extraction: it takes a 32-bit instruction template and a 64-bit immediate, scatters the immediate bits into the I/S/B/U/J field positions, and flags any immediate that the selected format cannot represent. Results pass through a 2-entry output FIFO with valid/ready handshakes on both sides. It feeds the instruction memory loader and the trap/patch logic.

---
 rtl/imm_encoder_if.sv | 32 +++
 rtl/imm_encoder.sv | 128 ++++++++++++
 tb/tb_imm_encoder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/imm_encoder_if.sv
// imm_encoder_if: handshake/data bundle for the immediate encoder.
//   Producer side: in_valid, in_instr, in_immSrc, in_imm -> in_ready back.
//   Consumer side: out_valid, out_instr, out_rangeErr, err_count -> out_ready back.
//   master: the block driving beats in and consuming results (loader / testbench).
//   slave : the encoder itself.
interface imm_encoder_if;
  localparam int InstrBusBits  = 32;
  localparam int DataBusBits   = 64;
  localparam int ImmSrcBusBits = 3;

  logic                     in_valid;
  logic                     in_ready;
  logic [InstrBusBits-1:0]  in_instr;
  logic [ImmSrcBusBits-1:0] in_immSrc;
  logic [DataBusBits-1:0]   in_imm;

  logic                     out_valid;
  logic                     out_ready;
  logic [InstrBusBits-1:0]  out_instr;
  logic                     out_rangeErr;
  logic [7:0]               err_count;

  modport master (
    output in_valid, in_instr, in_immSrc, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_rangeErr, err_count
  );

  modport slave (
    input  in_valid, in_instr, in_immSrc, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_rangeErr, err_count
  );
endinterface

// File: rtl/imm_encoder.sv
// imm_encoder: scatters a 64-bit two's-complement immediate into the I/S/B/U/J
// field positions of a 32-bit instruction template and flags immediates the
// selected format cannot represent. Results are queued in a 2-entry FIFO.
//   clk    : single clock, rising edge
//   reset  : synchronous, active-high
//   bus    : imm_encoder_if.slave (input beat handshake, output FIFO head,
//            saturating 8-bit count of accepted out-of-range beats)
//
// count | meaning
// 0     | empty, out_valid=0, in_ready=1
// 1     | one entry, out_valid=1, in_ready=1 (push+pop holds at 1)
// 2     | full, out_valid=1, in_ready=0
module imm_encoder (
  input  logic          clk,
  input  logic          reset,
  imm_encoder_if.slave  bus
);
  localparam int InstrBusBits  = 32;
  localparam int DataBusBits   = 64;
  localparam int ImmSrcBusBits = 3;

  localparam logic [ImmSrcBusBits-1:0] ImmSrcIType = 3'd0;
  localparam logic [ImmSrcBusBits-1:0] ImmSrcSType = 3'd1;
  localparam logic [ImmSrcBusBits-1:0] ImmSrcBType = 3'd2;
  localparam logic [ImmSrcBusBits-1:0] ImmSrcUType = 3'd3;
  localparam logic [ImmSrcBusBits-1:0] ImmSrcJType = 3'd4;

  localparam int EntryBits = InstrBusBits + 1;

  logic [InstrBusBits-1:0] enc_instr;
  logic                    enc_err;
  logic [DataBusBits-1:0]  imm;

  logic [EntryBits-1:0] fifo_mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count;
  logic [7:0]           err_cnt;
  logic                 push;
  logic                 pop;

  assign imm = bus.in_imm;

  // Range checks compare the full 64-bit value against the sign extension of
  // the representable slice, so any stray upper bit is an error.
  always_comb begin
    enc_instr = bus.in_instr;
    enc_err   = 1'b0;
    case (bus.in_immSrc)
      ImmSrcIType: begin
        enc_instr[31:20] = imm[11:0];
        enc_err          = (imm != {{52{imm[11]}}, imm[11:0]});
      end
      ImmSrcSType: begin
        enc_instr[31:25] = imm[11:5];
        enc_instr[11:7]  = imm[4:0];
        enc_err          = (imm != {{52{imm[11]}}, imm[11:0]});
      end
      ImmSrcBType: begin
        enc_instr[31]    = imm[12];
        enc_instr[30:25] = imm[10:5];
        enc_instr[11:8]  = imm[4:1];
        enc_instr[7]     = imm[11];
        enc_err          = (imm != {{51{imm[12]}}, imm[12:0]}) || imm[0];
      end
      ImmSrcUType: begin
        enc_instr[31:12] = imm[31:12];
        enc_err          = (imm[11:0] != 12'd0) ||
                           (imm != {{32{imm[31]}}, imm[31:0]});
      end
      ImmSrcJType: begin
        enc_instr[31]    = imm[20];
        enc_instr[30:21] = imm[10:1];
        enc_instr[20]    = imm[11];
        enc_instr[19:12] = imm[19:12];
        enc_err          = (imm != {{43{imm[20]}}, imm[20:0]}) || imm[0];
      end
      default: begin
        enc_err = 1'b1;
      end
    endcase
  end

  // Handshake flags depend only on the registered count, so out_ready never
  // reaches in_ready combinationally.
  assign bus.in_ready  = (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Storage carries no reset; stale entries are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_mem[wr_ptr] <= {enc_err, enc_instr};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      err_cnt <= 8'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      // Driven from the encoder output of the accepted beat, never from the
      // FIFO head, so an empty head cannot leak X into the counter.
      if (push && enc_err && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  assign bus.out_instr    = fifo_mem[rd_ptr][InstrBusBits-1:0];
  assign bus.out_rangeErr = fifo_mem[rd_ptr][InstrBusBits];
  assign bus.err_count    = err_cnt;
endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;
  localparam logic [2:0] FI = 3'd0;
  localparam logic [2:0] FS = 3'd1;
  localparam logic [2:0] FB = 3'd2;
  localparam logic [2:0] FU = 3'd3;
  localparam logic [2:0] FJ = 3'd4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;
  int   n_pop = 0;
  int   cyc = 0;
  logic [32:0] exp_q [$];
  logic [32:0] mon_e;

  imm_encoder_if bus ();

  imm_encoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: a pop happens at the next rising edge whenever
  // out_valid && out_ready is seen at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_bad++;
          $display("FAIL unexpected_beat: got instr 0x%0h with nothing expected", bus.out_instr);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_instr", {32'd0, bus.out_instr}, {32'd0, mon_e[31:0]});
          check("out_rangeErr", {63'd0, bus.out_rangeErr}, {63'd0, mon_e[32]});
        end
      end
    end
  end

  // Presents one beat and returns just after the edge where it was accepted.
  task automatic send(input logic [31:0] t, input logic [2:0] src, input logic [63:0] imm,
                      input logic [31:0] ei, input logic ee);
    bit done = 0;
    int waits = 0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = t;
    bus.in_immSrc = src;
    bus.in_imm    = imm;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        exp_q.push_back({ee, ei});
        done = 1;
      end else begin
        waits++;
        if (waits > 100) begin
          n_chk++;
          n_bad++;
          $display("FAIL accept_timeout: in_ready stuck at %0b for template 0x%0h", bus.in_ready, t);
          done = 1;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
    check("drain_out_valid", {63'd0, bus.out_valid}, 0);
  endtask

  initial begin
    int c0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_immSrc = '0;
    bus.in_imm    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_out_valid", {63'd0, bus.out_valid}, 0);
    check("rst_in_ready", {63'd0, bus.in_ready}, 1);
    check("rst_err_count", {56'd0, bus.err_count}, 0);

    // First beat: visible one cycle after the push.
    bus.out_ready = 1'b1;
    send(32'h0000_0013, FI, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFF0_0013, 1'b0);
    check("latency_out_valid", {63'd0, bus.out_valid}, 1);
    check("first_err_count", {56'd0, bus.err_count}, 0);
    drain();

    // Back-to-back burst: one beat per cycle.
    c0 = cyc;
    send(32'h0000_0063, FB, 64'd8,                   32'h0000_0463, 1'b0);
    send(32'h0000_006F, FJ, 64'h800,                 32'h0010_006F, 1'b0);
    send(32'h0000_0037, FU, 64'h1234_5000,           32'h1234_5037, 1'b0);
    send(32'h0000_2023, FS, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFE00_2E23, 1'b0);
    send(32'h0000_006F, FJ, 64'hFFFF_FFFF_FFFF_FFFE, 32'hFFFF_F06F, 1'b0);
    check("burst_cycles", cyc - c0, 5);
    drain();

    // Range errors.
    send(32'h0000_0013, FI, 64'd2048,   32'h8000_0013, 1'b1);
    send(32'h0000_0063, FB, 64'd7,      32'h0000_0363, 1'b1);
    send(32'h0000_0037, FU, 64'h1001,   32'h0000_1037, 1'b1);
    check("err_count_3", {56'd0, bus.err_count}, 3);

    // Range boundaries.
    send(32'h0000_0013, FI, 64'hFFFF_FFFF_FFFF_F800, 32'h8000_0013, 1'b0);
    send(32'h0000_0013, FI, 64'd2047,                32'h7FF0_0013, 1'b0);
    send(32'h0000_0063, FB, 64'hFFFF_FFFF_FFFF_F000, 32'h8000_0063, 1'b0);
    send(32'h0000_0063, FB, 64'd4096,                32'h8000_0063, 1'b1);
    send(32'h0000_0037, FU, 64'hFFFF_FFFF_8000_0000, 32'h8000_0037, 1'b0);
    send(32'h0000_0037, FU, 64'h0000_0000_8000_0000, 32'h8000_0037, 1'b1);
    send(32'h0000_006F, FJ, 64'h10_0000,             32'h8000_006F, 1'b1);
    send(32'hDEAD_BEEF, 3'd7, 64'd0,                 32'hDEAD_BEEF, 1'b1);
    check("err_count_7", {56'd0, bus.err_count}, 7);
    drain();

    // Backpressure: two accepted, third waits until the head is popped.
    bus.out_ready = 1'b0;
    send(32'h0000_0013, FI, 64'd1, 32'h0010_0013, 1'b0);
    send(32'h0000_0013, FI, 64'd2, 32'h0020_0013, 1'b0);
    @(negedge clk);
    check("full_in_ready", {63'd0, bus.in_ready}, 0);
    check("full_out_valid", {63'd0, bus.out_valid}, 1);
    repeat (2) @(negedge clk);
    check("stall_stable", {32'd0, bus.out_instr}, {32'd0, exp_q[0][31:0]});
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(32'h0000_0013, FI, 64'd3, 32'h0030_0013, 1'b0);
    drain();

    // Simultaneous push and pop at count=1.
    bus.out_ready = 1'b0;
    send(32'h0000_0013, FI, 64'd0, 32'h0000_0013, 1'b0);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      send(32'h0000_0013, FI, 64'(i), (32'(i) << 20) | 32'h13, 1'b0);
      check("sim_out_valid", {63'd0, bus.out_valid}, 1);
      check("sim_in_ready", {63'd0, bus.in_ready}, 1);
    end
    drain();

    // Reset while full.
    bus.out_ready = 1'b0;
    send(32'h0000_0063, FB, 64'd1, 32'h0000_0063, 1'b1);
    send(32'h0000_0063, FB, 64'd1, 32'h0000_0063, 1'b1);
    check("pre_rst_err_count", {56'd0, bus.err_count}, 9);
    check("pre_rst_in_ready", {63'd0, bus.in_ready}, 0);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    check("mid_rst_out_valid", {63'd0, bus.out_valid}, 0);
    check("mid_rst_in_ready", {63'd0, bus.in_ready}, 1);
    check("mid_rst_err_count", {56'd0, bus.err_count}, 0);

    // Saturation.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(32'h0000_0037, FU, 64'h1001, 32'h0000_1037, 1'b1);
      if (i == 253) check("err_count_254", {56'd0, bus.err_count}, 254);
      if (i == 254) check("err_count_255", {56'd0, bus.err_count}, 255);
    end
    check("err_count_sat", {56'd0, bus.err_count}, 255);
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
